// File: rtl/cdc_event_scheduler_pkg.sv
// Shared definitions for the event scheduler: FSM state encoding and
// the width-derivation helper used to validate ID_W against N_REQ.
package cdc_event_scheduler_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_ARM   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_ARM   = ST_ARM,
        S_WAIT  = ST_WAIT,
        S_FAULT = ST_FAULT
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cdc_event_scheduler_rr_pick.sv
// Combinational round-robin selector: first pending source at or after
// i_ptr, wrapping modulo N_REQ.
module cdc_event_scheduler_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id
);

    always_comb begin : p_pick
        int idx;
        idx     = 0;
        o_valid = 1'b0;
        o_id    = '0;
        // Scan from the farthest offset down so the nearest match wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(i_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (i_pending[idx]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cdc_event_scheduler.sv
// Shares one flag crossing between N_REQ event sources: per-source event
// counters, round-robin grant, one flag pulse per grant, busy timeout.
module cdc_event_scheduler
    import cdc_event_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic             clkA,
    input  logic             rstA_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             cdc_busy,
    input  logic             clr_err,
    output logic             cdc_flag,
    output logic [ID_W-1:0]  cdc_id,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overflow,
    output logic             timeout_err
);

    localparam int ID_MIN = clog2(N_REQ);

    generate
        if (ID_W < ID_MIN) begin : g_bad_id_w
            $error("ID_W too narrow for N_REQ");
        end
    endgenerate

    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_W-1:0]      r_cnt [N_REQ];
    logic [N_REQ-1:0]      r_ovf;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_id;
    logic                  r_flag;
    logic                  r_to_err;
    logic [TO_W-1:0]       r_to_cnt;
    logic [N_REQ-1:0]      w_pending;
    logic [N_REQ-1:0]      w_dec;
    logic [N_REQ-1:0]      w_full;
    logic                  w_pick_valid;
    logic [ID_W-1:0]       w_pick_id;
    logic                  w_issue_go;
    logic                  w_to_hit;

    cdc_event_scheduler_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_pending (w_pending),
        .i_ptr     (r_ptr),
        .o_valid   (w_pick_valid),
        .o_id      (w_pick_id)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_src
            // The granted source is debited on the edge that ends ISSUE.
            assign w_dec[gi]     = (r_state == S_ISSUE) && (r_id == ID_W'(gi));
            assign w_full[gi]    = (r_cnt[gi] == {CNT_W{1'b1}});
            assign w_pending[gi] = |r_cnt[gi];

            always_ff @(posedge clkA or negedge rstA_n) begin
                if (!rstA_n) begin
                    r_cnt[gi] <= '0;
                end else if (req_pulse[gi] && !w_dec[gi]) begin
                    if (!w_full[gi]) r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end else if (!req_pulse[gi] && w_dec[gi]) begin
                    r_cnt[gi] <= r_cnt[gi] - 1'b1;
                end
            end

            always_ff @(posedge clkA or negedge rstA_n) begin
                if (!rstA_n) begin
                    r_ovf[gi] <= 1'b0;
                end else if (req_pulse[gi] && !w_dec[gi] && w_full[gi]) begin
                    r_ovf[gi] <= 1'b1;
                end else if (clr_err) begin
                    r_ovf[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_issue_go   = 1'b0;
        w_to_hit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_pick_valid && !cdc_busy) begin
                    w_state_next = S_ISSUE;
                    w_issue_go   = 1'b1;
                end
            end
            S_ISSUE: w_state_next = S_ARM;
            // Busy may still show the previous round-trip here; ignore it.
            S_ARM:   w_state_next = S_WAIT;
            S_WAIT: begin
                if (!cdc_busy) begin
                    w_state_next = S_IDLE;
                end else if ((TIMEOUT != 0) && (r_to_cnt == TO_W'(TIMEOUT - 1))) begin
                    w_state_next = S_FAULT;
                    w_to_hit     = 1'b1;
                end
            end
            S_FAULT: begin
                if (clr_err) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clkA or negedge rstA_n) begin
        if (!rstA_n) begin
            r_state  <= S_IDLE;
            r_id     <= '0;
            r_ptr    <= '0;
            r_flag   <= 1'b0;
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_flag  <= w_issue_go;
            if (w_issue_go) begin
                r_id  <= w_pick_id;
                r_ptr <= (w_pick_id == ID_W'(N_REQ - 1)) ? '0 : w_pick_id + 1'b1;
            end
            if (r_state == S_ARM) begin
                r_to_cnt <= '0;
            end else if ((r_state == S_WAIT) && cdc_busy) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_hit) begin
                r_to_err <= 1'b1;
            end else if (clr_err) begin
                r_to_err <= 1'b0;
            end
        end
    end

    assign cdc_flag    = r_flag;
    assign cdc_id      = r_id;
    assign pending     = w_pending;
    assign overflow    = r_ovf;
    assign timeout_err = r_to_err;

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Directed bench for cdc_event_scheduler with a behavioural flag-crossing
// model that holds busy for BUSY_LEN cycles after each flag.
module tb_cdc_event_scheduler;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int CNT_W    = 4;
    localparam int TIMEOUT  = 16;
    localparam int TO_W     = 5;
    localparam int BUSY_LEN = 8;

    logic             clkA = 1'b0;
    logic             rstA_n;
    logic             en;
    logic [N_REQ-1:0] req_pulse;
    logic             cdc_busy;
    logic             clr_err;
    logic             cdc_flag;
    logic [ID_W-1:0]  cdc_id;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] overflow;
    logic             timeout_err;

    logic             stuck_busy = 1'b0;
    int               busy_cnt = 0;
    int               flag_cnt = 0;
    int               flag_busy_err = 0;
    logic [ID_W-1:0]  grant_log [0:127];

    int errors = 0;
    int checks = 0;

    cdc_event_scheduler #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clkA        (clkA),
        .rstA_n      (rstA_n),
        .en          (en),
        .req_pulse   (req_pulse),
        .cdc_busy    (cdc_busy),
        .clr_err     (clr_err),
        .cdc_flag    (cdc_flag),
        .cdc_id      (cdc_id),
        .pending     (pending),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clkA = ~clkA;

    assign cdc_busy = stuck_busy | (busy_cnt != 0);

    // Crossing model and flag monitor; the crossing is never reset.
    always @(posedge clkA) begin
        if (cdc_flag) begin
            if (flag_cnt < 128) grant_log[flag_cnt] <= cdc_id;
            flag_cnt <= flag_cnt + 1;
            if (cdc_busy) flag_busy_err <= flag_busy_err + 1;
            busy_cnt <= BUSY_LEN;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic do_reset();
        @(negedge clkA);
        rstA_n = 1'b0; en = 1'b0; req_pulse = '0; clr_err = 1'b0; stuck_busy = 1'b0;
        repeat (2) @(negedge clkA);
        rstA_n = 1'b1;
        @(negedge clkA);
    endtask

    task automatic wait_quiet(input string name, input int max_cyc);
        int q = 0;
        int n = 0;
        while (q < 3 && n < max_cyc) begin
            @(negedge clkA);
            n++;
            if (pending == '0 && !cdc_busy && !cdc_flag) q++;
            else q = 0;
        end
        checks++;
        if (q < 3) begin
            errors++;
            $display("FAIL %s_drain: still active after %0d cycles, pending=%b", name, n, pending);
        end
    endtask

    task automatic wait_flag(input string name, input int base, input int max_cyc);
        int n = 0;
        while (flag_cnt == base && n < max_cyc) begin
            @(negedge clkA);
            n++;
        end
        checks++;
        if (flag_cnt == base) begin
            errors++;
            $display("FAIL %s_flag_timeout: no cdc_flag within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({cdc_flag, cdc_id, pending, overflow, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got flag=%b id=%0d pend=%b ovf=%b to=%b, want all 0",
                     cdc_flag, cdc_id, pending, overflow, timeout_err);
        end
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_single_event();
        int base;
        do_reset();
        en = 1'b1;
        base = flag_cnt;
        @(negedge clkA); req_pulse = 4'b0001;
        @(negedge clkA); req_pulse = 4'b0000;
        checks++;
        if (pending !== 4'b0001 || cdc_flag !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle1: pending=%b flag=%b, want 0001/0", pending, cdc_flag);
        end
        @(negedge clkA);
        checks++;
        if (cdc_flag !== 1'b1 || cdc_id !== 2'd0) begin
            errors++;
            $display("FAIL single_flag: flag=%b id=%0d, want 1/0", cdc_flag, cdc_id);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clkA);
            checks++;
            if (cdc_flag !== 1'b0 || cdc_id !== 2'd0) begin
                errors++;
                $display("FAIL single_hold%0d: flag=%b id=%0d, want 0/0", i, cdc_flag, cdc_id);
            end
        end
        checks++;
        if (pending !== 4'b0000 || flag_cnt - base != 1) begin
            errors++;
            $display("FAIL single_done: pending=%b flags=%0d, want 0000/1", pending, flag_cnt - base);
        end
        $display("test_single_event: flags=%0d", flag_cnt - base);
    endtask

    task automatic test_fairness();
        int base;
        int bbase;
        int bad;
        do_reset();
        repeat (3) begin
            @(negedge clkA); req_pulse = 4'b1111;
        end
        @(negedge clkA); req_pulse = '0;
        checks++;
        if (pending !== 4'b1111) begin
            errors++;
            $display("FAIL fair_pending: pending=%b, want 1111", pending);
        end
        base  = flag_cnt;
        bbase = flag_busy_err;
        en = 1'b1;
        wait_quiet("fair", 600);
        checks++;
        if (flag_cnt - base != 12) begin
            errors++;
            $display("FAIL fair_count: flags=%0d, want 12", flag_cnt - base);
        end
        bad = 0;
        for (int j = 0; j < 12; j++) begin
            logic [ID_W-1:0] exp_id;
            exp_id = ID_W'(j % 4);
            if (grant_log[base + j] !== exp_id) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fair_order: %0d grants out of order, want 0,1,2,3 x3", bad);
        end
        checks++;
        if (flag_busy_err != bbase) begin
            errors++;
            $display("FAIL fair_busy: flags while busy=%0d, want 0", flag_busy_err - bbase);
        end
        $display("test_fairness: flags=%0d misordered=%0d", flag_cnt - base, bad);
    endtask

    task automatic test_saturation();
        int base;
        int bad;
        do_reset();
        base = flag_cnt;
        repeat (17) begin
            @(negedge clkA); req_pulse = 4'b0100;
        end
        @(negedge clkA); req_pulse = '0;
        checks++;
        if (overflow !== 4'b0100 || pending !== 4'b0100 || flag_cnt != base) begin
            errors++;
            $display("FAIL sat_fill: ovf=%b pend=%b flags=%0d, want 0100/0100/0",
                     overflow, pending, flag_cnt - base);
        end
        en = 1'b1;
        wait_quiet("sat", 800);
        checks++;
        if (flag_cnt - base != 15) begin
            errors++;
            $display("FAIL sat_grants: flags=%0d, want 15", flag_cnt - base);
        end
        bad = 0;
        for (int j = 0; j < 15; j++) if (grant_log[base + j] !== 2'd2) bad++;
        checks++;
        if (bad != 0 || overflow !== 4'b0100) begin
            errors++;
            $display("FAIL sat_ids: wrong ids=%0d ovf=%b, want 0/0100", bad, overflow);
        end
        @(negedge clkA); clr_err = 1'b1;
        @(negedge clkA); clr_err = 1'b0;
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL sat_clear: ovf=%b, want 0000", overflow);
        end
        $display("test_saturation: grants=%0d", flag_cnt - base);
    endtask

    task automatic test_simultaneous();
        int base;
        do_reset();
        en = 1'b1;
        base = flag_cnt;
        @(negedge clkA); req_pulse = 4'b0010;
        @(negedge clkA); req_pulse = 4'b0000;
        @(negedge clkA);
        checks++;
        if (cdc_flag !== 1'b1 || cdc_id !== 2'd1) begin
            errors++;
            $display("FAIL simul_flag: flag=%b id=%0d, want 1/1", cdc_flag, cdc_id);
        end
        req_pulse = 4'b0010;
        @(negedge clkA); req_pulse = 4'b0000;
        checks++;
        if (pending !== 4'b0010) begin
            errors++;
            $display("FAIL simul_count: pending=%b, want 0010", pending);
        end
        wait_quiet("simul", 200);
        checks++;
        if (flag_cnt - base != 2 || grant_log[base + 1] !== 2'd1) begin
            errors++;
            $display("FAIL simul_second: flags=%0d id2=%0d, want 2/1", flag_cnt - base, grant_log[base + 1]);
        end
        $display("test_simultaneous: flags=%0d", flag_cnt - base);
    endtask

    task automatic test_stuck_busy();
        int base;
        do_reset();
        en = 1'b1;
        base = flag_cnt;
        @(negedge clkA); req_pulse = 4'b1000;
        @(negedge clkA);
        @(negedge clkA); req_pulse = 4'b0000;
        checks++;
        if (cdc_flag !== 1'b1 || cdc_id !== 2'd3) begin
            errors++;
            $display("FAIL stuck_flag: flag=%b id=%0d, want 1/3", cdc_flag, cdc_id);
        end
        stuck_busy = 1'b1;
        repeat (17) @(negedge clkA);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL stuck_early: timeout_err=%b after 15 WAIT cycles, want 0", timeout_err);
        end
        @(negedge clkA);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL stuck_timeout: timeout_err=%b after 16 WAIT cycles, want 1", timeout_err);
        end
        repeat (30) @(negedge clkA);
        checks++;
        if (flag_cnt - base != 1 || pending !== 4'b1000 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL stuck_fault: flags=%0d pend=%b to=%b, want 1/1000/1",
                     flag_cnt - base, pending, timeout_err);
        end
        stuck_busy = 1'b0;
        @(negedge clkA); clr_err = 1'b1;
        @(negedge clkA); clr_err = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL stuck_clear: timeout_err=%b, want 0", timeout_err);
        end
        wait_flag("stuck", base + 1, 20);
        @(negedge clkA);
        checks++;
        if (grant_log[base + 1] !== 2'd3) begin
            errors++;
            $display("FAIL stuck_resume: id=%0d, want 3", grant_log[base + 1]);
        end
        wait_quiet("stuck", 200);
        $display("test_stuck_busy: flags=%0d", flag_cnt - base);
    endtask

    task automatic test_reset_mid_wait();
        int base;
        do_reset();
        en = 1'b1;
        base = flag_cnt;
        @(negedge clkA); req_pulse = 4'b0001;
        @(negedge clkA); req_pulse = 4'b0000;
        wait_flag("rstwait", base, 20);
        stuck_busy = 1'b1;
        repeat (5) @(negedge clkA);
        rstA_n = 1'b0;
        #1;
        checks++;
        if ({cdc_flag, cdc_id, pending, overflow, timeout_err} !== '0) begin
            errors++;
            $display("FAIL rstwait_async: flag=%b id=%0d pend=%b ovf=%b to=%b, want all 0",
                     cdc_flag, cdc_id, pending, overflow, timeout_err);
        end
        @(negedge clkA); rstA_n = 1'b1;
        base = flag_cnt;
        @(negedge clkA); req_pulse = 4'b0100;
        @(negedge clkA); req_pulse = 4'b0000;
        repeat (10) @(negedge clkA);
        checks++;
        if (flag_cnt != base || pending !== 4'b0100 || cdc_id !== 2'd0) begin
            errors++;
            $display("FAIL rstwait_blocked: flags=%0d pend=%b id=%0d, want 0/0100/0",
                     flag_cnt - base, pending, cdc_id);
        end
        stuck_busy = 1'b0;
        wait_flag("rstwait2", base, 30);
        @(negedge clkA);
        checks++;
        if (grant_log[base] !== 2'd2) begin
            errors++;
            $display("FAIL rstwait_resume: id=%0d, want 2", grant_log[base]);
        end
        wait_quiet("rstwait", 200);
        $display("test_reset_mid_wait: flags after release=%0d", flag_cnt - base);
    endtask

    initial begin
        rstA_n = 1'b0; en = 1'b0; req_pulse = '0; clr_err = 1'b0;
        repeat (2) @(negedge clkA);
        test_reset();
        test_single_event();
        test_fairness();
        test_saturation();
        test_simultaneous();
        test_stuck_busy();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
